// File: rtl/nes_mapper_pkg.sv
// nes_mapper_pkg: shared identifiers for the cartridge mapper.
//  - MAPPER_* : mapper ids selected by the MAPPER parameter
//  - MIR_*    : nametable mirroring encodings (also MMC1 ctrl[1:0])
//  - MMC1_SEL_* / PRG_MODE_* : MMC1 register select and PRG banking modes
//  - mirror_a10() : nametable A10 after mirroring
package nes_mapper_pkg;

  localparam int MAPPER_NROM  = 0;
  localparam int MAPPER_MMC1  = 1;
  localparam int MAPPER_UXROM = 2;
  localparam int MAPPER_CNROM = 3;

  localparam logic [1:0] MIR_1SCR_LO = 2'd0;
  localparam logic [1:0] MIR_1SCR_HI = 2'd1;
  localparam logic [1:0] MIR_VERT    = 2'd2;
  localparam logic [1:0] MIR_HORZ    = 2'd3;

  localparam logic [1:0] MMC1_SEL_CTRL = 2'd0;
  localparam logic [1:0] MMC1_SEL_CHR0 = 2'd1;
  localparam logic [1:0] MMC1_SEL_CHR1 = 2'd2;
  localparam logic [1:0] MMC1_SEL_PRG  = 2'd3;

  localparam logic [1:0] PRG_MODE_32K_A     = 2'd0;
  localparam logic [1:0] PRG_MODE_32K_B     = 2'd1;
  localparam logic [1:0] PRG_MODE_FIX_FIRST = 2'd2;
  localparam logic [1:0] PRG_MODE_FIX_LAST  = 2'd3;

  localparam logic [4:0] MMC1_CTRL_RESET = 5'h0C;

  // a11_10 is ppu_addr[11:10]; returns the CIRAM page bit.
  function automatic logic mirror_a10(input logic [1:0] mode, input logic [1:0] a11_10);
    logic r;
    case (mode)
      MIR_1SCR_LO: r = 1'b0;
      MIR_1SCR_HI: r = 1'b1;
      MIR_VERT:    r = a11_10[0];
      MIR_HORZ:    r = a11_10[1];
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nes_mapper_if.sv
// nes_mapper_if: CPU bus, PPU bus and memory-macro signals around the mapper.
//  master: board side (CPU/PPU/memories) driving addresses, strobes and memory data.
//  slave : the mapper, driving read muxes, memory addresses and write enables.
interface nes_mapper_if #(
  parameter int PRG_AW = 17,
  parameter int CHR_AW = 13
);
  logic [15:0]       address;
  logic [7:0]        cpu_out;
  logic              we;
  logic [7:0]        in;
  logic [10:0]       ram_addr;
  logic              ram_we;
  logic [7:0]        ram_q;
  logic [PRG_AW-1:0] prg_addr;
  logic [7:0]        prg_q;
  logic [13:0]       ppu_addr;
  logic [7:0]        ppu_out;
  logic              ppu_we;
  logic [7:0]        ppu_in;
  logic [CHR_AW-1:0] chr_addr;
  logic              chr_we;
  logic [7:0]        chr_q;
  logic [10:0]       vram_addr;
  logic              vram_we;
  logic [7:0]        vram_q;

  modport master (
    output address, cpu_out, we, ram_q, prg_q, ppu_addr, ppu_out, ppu_we, chr_q, vram_q,
    input  in, ram_addr, ram_we, prg_addr, ppu_in, chr_addr, chr_we, vram_addr, vram_we
  );

  modport slave (
    input  address, cpu_out, we, ram_q, prg_q, ppu_addr, ppu_out, ppu_we, chr_q, vram_q,
    output in, ram_addr, ram_we, prg_addr, ppu_in, chr_addr, chr_we, vram_addr, vram_we
  );
endinterface

// File: rtl/nes_mapper_mmc1_regs.sv
// nes_mapper_mmc1_regs: MMC1 serial loader and its four internal registers.
//  clock, reset : system clock, synchronous active-high reset
//  wr_ev        : one pulse per CPU write strobe into $8000-$FFFF
//  bit_in       : cpu_out[0], serial data bit
//  clear        : cpu_out[7], aborts the sequence and forces PRG mode 3
//  sel          : address[14:13], target register on the fifth bit
//  ctrl/chr0/chr1/prg : registered bank/mode state (prg holds bank bits only)
module nes_mapper_mmc1_regs
  import nes_mapper_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_ev,
  input  logic       bit_in,
  input  logic       clear,
  input  logic [1:0] sel,
  output logic [4:0] ctrl,
  output logic [4:0] chr0,
  output logic [4:0] chr1,
  output logic [3:0] prg
);

  logic [4:0] shift;
  logic [2:0] cnt;
  logic [4:0] next_val;

  // Bits arrive LSB first, so new data enters at the top.
  assign next_val = {bit_in, shift[4:1]};

  // Serial shift register, bit counter and register commit on the fifth bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift <= 5'd0;
      cnt   <= 3'd0;
      ctrl  <= MMC1_CTRL_RESET;
      chr0  <= 5'd0;
      chr1  <= 5'd0;
      prg   <= 4'd0;
    end else if (wr_ev) begin
      if (clear) begin
        shift <= 5'd0;
        cnt   <= 3'd0;
        ctrl  <= ctrl | MMC1_CTRL_RESET;
      end else if (cnt == 3'd4) begin
        shift <= 5'd0;
        cnt   <= 3'd0;
        case (sel)
          MMC1_SEL_CTRL: ctrl <= next_val;
          MMC1_SEL_CHR0: chr0 <= next_val;
          MMC1_SEL_CHR1: chr1 <= next_val;
          MMC1_SEL_PRG:  prg  <= next_val[3:0];
          default:       ctrl <= ctrl;
        endcase
      end else begin
        shift <= next_val;
        cnt   <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/nes_mapper.sv
// nes_mapper: cartridge mapper and memory router between CPU/PPU buses and RAM/ROM macros.
//  clock, reset : system clock, synchronous active-high reset
//  bus (slave)  : CPU address/data/strobe, PPU address/strobe, memory data in;
//                 read muxes, memory addresses and write enables out.
// Bank decode is combinational; bank/mirroring state updates from CPU writes to $8000-$FFFF.
module nes_mapper
  import nes_mapper_pkg::*;
#(
  parameter int MAPPER  = 1,
  parameter int PRG_AW  = 17,
  parameter int CHR_AW  = 13,
  parameter int CHR_RAM = 0,
  parameter int MIRROR  = 2
) (
  input logic           clock,
  input logic           reset,
  nes_mapper_if.slave   bus
);

  logic              we_d;
  logic              wr_ev;
  logic [7:0]        ux_bank;
  logic [7:0]        cn_bank;
  logic [4:0]        ctrl;
  logic [4:0]        chr0;
  logic [4:0]        chr1;
  logic [3:0]        prg;
  logic [7:0]        prg_bank;
  logic [CHR_AW-1:0] chr_sel;
  logic [1:0]        mir_mode;

  // A strobe held high for several cycles produces a single event.
  assign wr_ev = bus.we & ~we_d & bus.address[15];

  // Strobe edge detector and the single-register UxROM/CNROM bank latches.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_d    <= 1'b0;
      ux_bank <= 8'd0;
      cn_bank <= 8'd0;
    end else begin
      we_d <= bus.we;
      if (wr_ev && (MAPPER == MAPPER_UXROM)) begin
        ux_bank <= bus.cpu_out;
      end
      if (wr_ev && (MAPPER == MAPPER_CNROM)) begin
        cn_bank <= bus.cpu_out;
      end
    end
  end

  generate
    if (MAPPER == MAPPER_MMC1) begin : g_mmc1
      nes_mapper_mmc1_regs u_regs (
        .clock  (clock),
        .reset  (reset),
        .wr_ev  (wr_ev),
        .bit_in (bus.cpu_out[0]),
        .clear  (bus.cpu_out[7]),
        .sel    (bus.address[14:13]),
        .ctrl   (ctrl),
        .chr0   (chr0),
        .chr1   (chr1),
        .prg    (prg)
      );
    end else begin : g_no_mmc1
      assign ctrl = MMC1_CTRL_RESET;
      assign chr0 = 5'd0;
      assign chr1 = 5'd0;
      assign prg  = 4'd0;
    end
  endgenerate

  // Bank and mirroring decode. Banks are 16K (PRG) numbers; "last bank" is all ones,
  // and the final width cast wraps any bank number to the image size.
  always_comb begin
    prg_bank = {7'd0, bus.address[14]};
    chr_sel  = CHR_AW'(bus.ppu_addr[12:0]);
    mir_mode = 2'(MIRROR);
    case (MAPPER)
      MAPPER_MMC1: begin
        mir_mode = ctrl[1:0];
        case (ctrl[3:2])
          PRG_MODE_32K_A, PRG_MODE_32K_B: prg_bank = {4'd0, prg[3:1], bus.address[14]};
          PRG_MODE_FIX_FIRST:             prg_bank = bus.address[14] ? {4'd0, prg} : 8'd0;
          PRG_MODE_FIX_LAST:              prg_bank = bus.address[14] ? 8'hFF : {4'd0, prg};
          default:                        prg_bank = 8'hFF;
        endcase
        if (ctrl[4]) begin
          chr_sel = CHR_AW'({(bus.ppu_addr[12] ? chr1 : chr0), bus.ppu_addr[11:0]});
        end else begin
          chr_sel = CHR_AW'({chr0[4:1], bus.ppu_addr[12:0]});
        end
      end
      MAPPER_UXROM: prg_bank = bus.address[14] ? 8'hFF : ux_bank;
      MAPPER_CNROM: chr_sel  = CHR_AW'({cn_bank, bus.ppu_addr[12:0]});
      default:      prg_bank = {7'd0, bus.address[14]};
    endcase
  end

  assign bus.prg_addr  = PRG_AW'({prg_bank, bus.address[13:0]});
  assign bus.chr_addr  = chr_sel;
  assign bus.vram_addr = {mirror_a10(mir_mode, bus.ppu_addr[11:10]), bus.ppu_addr[9:0]};

  assign bus.ram_addr = bus.address[10:0];
  assign bus.ram_we   = bus.we & (bus.address[15:13] == 3'b000);
  assign bus.chr_we   = bus.ppu_we & ~bus.ppu_addr[13] & (CHR_RAM != 0);
  assign bus.vram_we  = bus.ppu_we & (bus.ppu_addr[13:12] == 2'b10);

  // CPU read: work RAM below $2000, PRG-ROM at $8000+, open bus elsewhere.
  assign bus.in = (bus.address[15:13] == 3'b000) ? bus.ram_q :
                  bus.address[15]                ? bus.prg_q : 8'hFF;

  // PPU read: pattern tables, nametables, else open bus (palette lives in the PPU).
  assign bus.ppu_in = ~bus.ppu_addr[13]                ? bus.chr_q  :
                      (bus.ppu_addr[13:12] == 2'b10)   ? bus.vram_q : 8'hFF;

endmodule

// File: tb/tb_nes_mapper.sv
// tb_nes_mapper: four mapper configurations sharing one CPU/PPU stimulus bus.
//  u0: NROM  PRG_AW=14 CHR_RAM=1 one-screen-high
//  u1: MMC1  PRG_AW=17 CHR_AW=17
//  u2: UxROM PRG_AW=17 vertical
//  u3: CNROM CHR_AW=15 horizontal
module tb_nes_mapper;

  localparam int F_PRG = 0, F_CHR = 1, F_VRAM = 2, F_IN = 3, F_PPUIN = 4;
  localparam int F_RAMWE = 5, F_CHRWE = 6, F_VRAMWE = 7, F_RAMADDR = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] address = 16'h0000;
  logic [7:0]  cpu_out = 8'h00;
  logic        we = 1'b0;
  logic [13:0] ppu_addr = 14'h0000;
  logic        ppu_we = 1'b0;

  always #5 clock = ~clock;

  nes_mapper_if #(.PRG_AW(14), .CHR_AW(13)) b0 ();
  nes_mapper_if #(.PRG_AW(17), .CHR_AW(17)) b1 ();
  nes_mapper_if #(.PRG_AW(17), .CHR_AW(13)) b2 ();
  nes_mapper_if #(.PRG_AW(17), .CHR_AW(15)) b3 ();

  nes_mapper #(.MAPPER(0), .PRG_AW(14), .CHR_AW(13), .CHR_RAM(1), .MIRROR(1))
    u0 (.clock(clock), .reset(reset), .bus(b0));
  nes_mapper #(.MAPPER(1), .PRG_AW(17), .CHR_AW(17), .CHR_RAM(0), .MIRROR(2))
    u1 (.clock(clock), .reset(reset), .bus(b1));
  nes_mapper #(.MAPPER(2), .PRG_AW(17), .CHR_AW(13), .CHR_RAM(0), .MIRROR(2))
    u2 (.clock(clock), .reset(reset), .bus(b2));
  nes_mapper #(.MAPPER(3), .PRG_AW(17), .CHR_AW(15), .CHR_RAM(0), .MIRROR(3))
    u3 (.clock(clock), .reset(reset), .bus(b3));

`define DRIVE(b) \
  assign b.address = address;  assign b.cpu_out = cpu_out; assign b.we = we; \
  assign b.ram_q = 8'hA1;      assign b.prg_q = 8'hB2;     assign b.ppu_addr = ppu_addr; \
  assign b.ppu_out = 8'h5A;    assign b.ppu_we = ppu_we;   assign b.chr_q = 8'hC3; \
  assign b.vram_q = 8'hD4;

  `DRIVE(b0)
  `DRIVE(b1)
  `DRIVE(b2)
  `DRIVE(b3)

  logic [31:0] obs [4][9];

`define OBS(d, b) \
  assign obs[d][0] = 32'(b.prg_addr);  assign obs[d][1] = 32'(b.chr_addr); \
  assign obs[d][2] = 32'(b.vram_addr); assign obs[d][3] = 32'(b.in); \
  assign obs[d][4] = 32'(b.ppu_in);    assign obs[d][5] = 32'(b.ram_we); \
  assign obs[d][6] = 32'(b.chr_we);    assign obs[d][7] = 32'(b.vram_we); \
  assign obs[d][8] = 32'(b.ram_addr);

  `OBS(0, b0)
  `OBS(1, b1)
  `OBS(2, b2)
  `OBS(3, b3)

  typedef struct {
    string       name;
    int          dut;
    int          fld;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [13:0] paddr;
    logic        we;
    logic        pwe;
    int          dut;
    int          fld;
    logic [31:0] exp;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic sb_push(string nm, int d, int f, logic [31:0] e);
    exp_t x;
    x.name = nm; x.dut = d; x.fld = f; x.exp = e;
    sbq.push_back(x);
  endtask

  // Outputs are combinational; compare everything queued at the next falling edge.
  task automatic drain();
    exp_t x;
    @(negedge clock);
    while (sbq.size() > 0) begin
      x = sbq.pop_front();
      n_cmp++;
      if (obs[x.dut][x.fld] !== x.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", x.name, obs[x.dut][x.fld], x.exp);
      end
    end
  endtask

  task automatic chk(string nm, logic [15:0] a, logic [13:0] pa, int d, int f, logic [31:0] e);
    address  = a;
    ppu_addr = pa;
    sb_push(nm, d, f, e);
    drain();
  endtask

  task automatic do_reset();
    we = 1'b0;
    ppu_we = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // One strobe, then a low cycle so the next write is a fresh edge.
  task automatic cpu_write(logic [15:0] a, logic [7:0] d);
    address = a;
    cpu_out = d;
    we = 1'b1;
    @(posedge clock);
    #1 we = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic mmc1_load(logic [15:0] a, logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      cpu_write(a, {7'd0, v[i]});
    end
  endtask

  initial begin
    tbl.push_back('{"rst_c000",      16'hC000, 14'h0000, 1'b0, 1'b0, 1, F_PRG,    32'h1C000});
    tbl.push_back('{"rst_8000",      16'h8000, 14'h0000, 1'b0, 1'b0, 1, F_PRG,    32'h00000});
    tbl.push_back('{"rst_fffc",      16'hFFFC, 14'h0000, 1'b0, 1'b0, 1, F_PRG,    32'h1FFFC});
    tbl.push_back('{"mmc1_chr_rst",  16'h0000, 14'h1234, 1'b0, 1'b0, 1, F_CHR,    32'h01234});
    tbl.push_back('{"mmc1_mir_lo",   16'h0000, 14'h2C00, 1'b0, 1'b0, 1, F_VRAM,   32'h000});
    tbl.push_back('{"mmc1_mir_lo2",  16'h0000, 14'h2BFF, 1'b0, 1'b0, 1, F_VRAM,   32'h3FF});
    tbl.push_back('{"in_ram",        16'h0123, 14'h0000, 1'b0, 1'b0, 1, F_IN,     32'hA1});
    tbl.push_back('{"in_prg",        16'h8000, 14'h0000, 1'b0, 1'b0, 1, F_IN,     32'hB2});
    tbl.push_back('{"in_open",       16'h4000, 14'h0000, 1'b0, 1'b0, 1, F_IN,     32'hFF});
    tbl.push_back('{"in_ppureg",     16'h2002, 14'h0000, 1'b0, 1'b0, 1, F_IN,     32'hFF});
    tbl.push_back('{"ppuin_chr",     16'h0000, 14'h0100, 1'b0, 1'b0, 1, F_PPUIN,  32'hC3});
    tbl.push_back('{"ppuin_vram",    16'h0000, 14'h2100, 1'b0, 1'b0, 1, F_PPUIN,  32'hD4});
    tbl.push_back('{"ppuin_pal",     16'h0000, 14'h3F00, 1'b0, 1'b0, 1, F_PPUIN,  32'hFF});
    tbl.push_back('{"ram_we_lo",     16'h0800, 14'h0000, 1'b1, 1'b0, 1, F_RAMWE,  32'h1});
    tbl.push_back('{"ram_we_2000",   16'h2000, 14'h0000, 1'b1, 1'b0, 1, F_RAMWE,  32'h0});
    tbl.push_back('{"ram_we_6000",   16'h6000, 14'h0000, 1'b1, 1'b0, 1, F_RAMWE,  32'h0});
    tbl.push_back('{"ram_addr",      16'h1FFF, 14'h0000, 1'b0, 1'b0, 1, F_RAMADDR,32'h7FF});
    tbl.push_back('{"ux_c123",       16'hC123, 14'h0000, 1'b0, 1'b0, 2, F_PRG,    32'h1C123});
    tbl.push_back('{"ux_8123",       16'h8123, 14'h0000, 1'b0, 1'b0, 2, F_PRG,    32'h00123});
    tbl.push_back('{"ux_vert",       16'h0000, 14'h2C05, 1'b0, 1'b0, 2, F_VRAM,   32'h405});
    tbl.push_back('{"ux_vert2",      16'h0000, 14'h2805, 1'b0, 1'b0, 2, F_VRAM,   32'h005});
    tbl.push_back('{"cn_chr_rst",    16'h0000, 14'h0456, 1'b0, 1'b0, 3, F_CHR,    32'h0456});
    tbl.push_back('{"cn_horz",       16'h0000, 14'h2C05, 1'b0, 1'b0, 3, F_VRAM,   32'h405});
    tbl.push_back('{"cn_horz2",      16'h0000, 14'h2405, 1'b0, 1'b0, 3, F_VRAM,   32'h005});
    tbl.push_back('{"cn_prg",        16'hC123, 14'h0000, 1'b0, 1'b0, 3, F_PRG,    32'h4123});
    tbl.push_back('{"nrom_prg14",    16'hC123, 14'h0000, 1'b0, 1'b0, 0, F_PRG,    32'h0123});
    tbl.push_back('{"nrom_1scr_hi",  16'h0000, 14'h2005, 1'b0, 1'b0, 0, F_VRAM,   32'h405});
    tbl.push_back('{"nrom_chrwe",    16'h0000, 14'h0010, 1'b0, 1'b1, 0, F_CHRWE,  32'h1});
    tbl.push_back('{"nrom_chrwe_nt", 16'h0000, 14'h2010, 1'b0, 1'b1, 0, F_CHRWE,  32'h0});
    tbl.push_back('{"nrom_vramwe",   16'h0000, 14'h2010, 1'b0, 1'b1, 0, F_VRAMWE, 32'h1});
    tbl.push_back('{"nrom_vramwe_p", 16'h0000, 14'h3010, 1'b0, 1'b1, 0, F_VRAMWE, 32'h0});
    tbl.push_back('{"mmc1_chrwe_rom",16'h0000, 14'h0010, 1'b0, 1'b1, 1, F_CHRWE,  32'h0});

    do_reset();

    // Post-reset decode across all configurations.
    foreach (tbl[i]) begin
      address  = tbl[i].addr;
      ppu_addr = tbl[i].paddr;
      we       = tbl[i].we;
      ppu_we   = tbl[i].pwe;
      sb_push(tbl[i].name, tbl[i].dut, tbl[i].fld, tbl[i].exp);
      drain();
    end
    we = 1'b0;
    ppu_we = 1'b0;

    // MMC1 PRG register: 1,0,1,0,0 -> prg=5; nothing commits before the fifth bit.
    do_reset();
    cpu_write(16'hE000, 8'h01);
    cpu_write(16'hE000, 8'h00);
    cpu_write(16'hE000, 8'h01);
    cpu_write(16'hE000, 8'h00);
    chk("mmc1_4th_bank0", 16'h8000, 14'h0000, 1, F_PRG, 32'h00000);
    cpu_write(16'hE000, 8'h00);
    chk("mmc1_prg5",      16'h8000, 14'h0000, 1, F_PRG, 32'h14000);
    chk("mmc1_prg5_last", 16'hC000, 14'h0000, 1, F_PRG, 32'h1C000);

    // Abort after 3 bits, then ctrl=00010: 32K PRG mode, vertical mirroring.
    do_reset();
    cpu_write(16'h8000, 8'h01);
    cpu_write(16'h8000, 8'h01);
    cpu_write(16'h8000, 8'h01);
    cpu_write(16'h8000, 8'h80);
    mmc1_load(16'h8000, 5'b00010);
    chk("mmc1_vert_2c00", 16'h0000, 14'h2C00, 1, F_VRAM, 32'h400);
    chk("mmc1_vert_2800", 16'h0000, 14'h2800, 1, F_VRAM, 32'h000);
    chk("mmc1_32k_c000",  16'hC000, 14'h0000, 1, F_PRG,  32'h04000);
    chk("mmc1_32k_8000",  16'h8000, 14'h0000, 1, F_PRG,  32'h00000);

    // 4K CHR mode with separate chr0/chr1 banks.
    do_reset();
    mmc1_load(16'h8000, 5'b10000);
    mmc1_load(16'hA000, 5'b00011);
    mmc1_load(16'hC000, 5'b00101);
    chk("mmc1_chr0_4k", 16'h0000, 14'h0123, 1, F_CHR, 32'h03123);
    chk("mmc1_chr1_4k", 16'h0000, 14'h1123, 1, F_CHR, 32'h05123);

    // Strobe held four cycles counts as one bit.
    do_reset();
    address = 16'hE000;
    cpu_out = 8'h01;
    we = 1'b1;
    repeat (4) @(posedge clock);
    #1 we = 1'b0;
    @(posedge clock);
    #1;
    cpu_write(16'hE000, 8'h00);
    cpu_write(16'hE000, 8'h00);
    cpu_write(16'hE000, 8'h00);
    chk("hold_pending", 16'h8000, 14'h0000, 1, F_PRG, 32'h00000);
    cpu_write(16'hE000, 8'h00);
    chk("hold_once", 16'h8000, 14'h0000, 1, F_PRG, 32'h04000);

    // Reset mid-sequence discards the partial shift.
    do_reset();
    cpu_write(16'hE000, 8'h01);
    cpu_write(16'hE000, 8'h01);
    do_reset();
    mmc1_load(16'hE000, 5'b00011);
    chk("mmc1_rst_mid", 16'h8000, 14'h0000, 1, F_PRG, 32'h0C000);

    // A write during reset is lost.
    reset = 1'b1;
    address = 16'h8000;
    cpu_out = 8'h0A;
    we = 1'b1;
    @(posedge clock);
    #1 we = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("ux_rst_beats_wr", 16'h8123, 14'h0000, 2, F_PRG, 32'h00123);
    chk("cn_rst_beats_wr", 16'h8123, 14'h0456, 3, F_CHR, 32'h0456);

    // UxROM switching, wrap, and ignored $6000 writes.
    do_reset();
    cpu_write(16'h8000, 8'h07);
    chk("ux_bank7",      16'h8123, 14'h0000, 2, F_PRG, 32'h1C123);
    chk("ux_fixed_last", 16'hC123, 14'h0000, 2, F_PRG, 32'h1C123);
    cpu_write(16'h8000, 8'h0A);
    chk("ux_wrap_0a",    16'h8123, 14'h0000, 2, F_PRG, 32'h08123);
    cpu_write(16'h6000, 8'h03);
    chk("ux_6000_ign",   16'h8123, 14'h0000, 2, F_PRG, 32'h08123);
    cpu_write(16'h8000, 8'h1F);
    chk("ux_wrap_1f",    16'h8123, 14'h0000, 2, F_PRG, 32'h1C123);

    // CNROM CHR banking and PPU write routing.
    do_reset();
    cpu_write(16'h8000, 8'h02);
    chk("cn_bank2", 16'h0000, 14'h0456, 3, F_CHR, 32'h4456);
    ppu_we = 1'b1;
    chk("cn_vram_we", 16'h0000, 14'h2400, 3, F_VRAMWE, 32'h1);
    chk("cn_chr_we",  16'h0000, 14'h2400, 3, F_CHRWE,  32'h0);
    ppu_we = 1'b0;
    cpu_write(16'h8000, 8'h05);
    chk("cn_wrap5", 16'h0000, 14'h0456, 3, F_CHR, 32'h2456);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
